fifo_gamma_reader: RTL



---
 rtl/fifo_gamma_reader.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_gamma_reader.sv
// fifo_gamma_reader: credit-based async-FIFO drain, skid buffer and gamma LUT stage; FIFO_GAMMA_READER_ERRCHK_EN adds protocolErr
module fifo_gamma_reader #(
  parameter int DATAWIDTH   = 8,
  parameter int SKIDDEPTH   = 4,
  parameter int FIFOLATENCY = 2
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic                 fifoRstDone,
  input  logic                 fifoEmpty,
  output logic                 fifoReadEn,
  input  logic [DATAWIDTH-1:0] fifoDataOut,
  input  logic                 fifoDataOutValid,
  input  logic                 lutWrEn,
  input  logic [DATAWIDTH-1:0] lutWrAddr,
  input  logic [DATAWIDTH-1:0] lutWrData,
  input  logic                 lutBypass,
  output logic [DATAWIDTH-1:0] pixOut,
  output logic                 pixValid,
  input  logic                 pixReady
`ifdef FIFO_GAMMA_READER_ERRCHK_EN
  ,
  output logic                 protocolErr
`endif
);
  localparam int PW = $clog2(SKIDDEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]        inflight;
  logic [CW-1:0]        skidCount;
  logic [PW-1:0]        wrPtr;
  logic [PW-1:0]        rdPtr;
  logic [DATAWIDTH-1:0] skid [SKIDDEPTH];
  logic [DATAWIDTH-1:0] lut [2**DATAWIDTH];
  logic [CW:0]          credit;
  logic                 push;
  logic                 pop;
  logic [DATAWIDTH-1:0] skidHead;

  // read credits cover words in flight plus words parked in the skid buffer
  always_comb begin
    credit     = {1'b0, skidCount} + {1'b0, inflight};
    fifoReadEn = fifoRstDone & ~fifoEmpty & ~rstIn & (credit < (CW+1)'(SKIDDEPTH));
    push       = fifoDataOutValid & (inflight != '0);
    pop        = (skidCount != '0) & (~pixValid | pixReady);
    skidHead   = skid[rdPtr];
  end

  // in-flight counter and skid buffer pointers
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      inflight  <= '0;
      skidCount <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
    end else begin
      inflight  <= inflight + CW'(fifoReadEn) - CW'(push);
      skidCount <= skidCount + CW'(push) - CW'(pop);
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
    end
  end

  // skid storage holds returned words; contents need no reset
  always_ff @(posedge clkIn) begin
    if (push) skid[wrPtr] <= fifoDataOut;
  end

  // gamma LUT write port; the read in the output register sees the old value
  always_ff @(posedge clkIn) begin
    if (lutWrEn) lut[lutWrAddr] <= lutWrData;
  end

  // output register: load on pop, hold under stall, drop valid when accepted
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      pixValid <= 1'b0;
      pixOut   <= '0;
    end else if (pop) begin
      pixValid <= 1'b1;
      pixOut   <= lutBypass ? skidHead : lut[skidHead];
    end else if (pixReady) begin
      pixValid <= 1'b0;
    end
  end

`ifdef FIFO_GAMMA_READER_ERRCHK_EN
  localparam int MW = $clog2(FIFOLATENCY + 2);
  logic [MW-1:0] maskCnt;

  // sticky error on stray returns (outside the post-reset window) or skid overflow
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      maskCnt     <= MW'(FIFOLATENCY);
      protocolErr <= 1'b0;
    end else begin
      if (maskCnt != '0) maskCnt <= maskCnt - MW'(1);
      if ((fifoDataOutValid & (inflight == '0) & (maskCnt == '0)) |
          (push & (skidCount == CW'(SKIDDEPTH)))) protocolErr <= 1'b1;
    end
  end
`endif
endmodule
